// File: rtl/chi_inv_engine.sv
// chi_inv_engine: iterative Keccak chi inverse, PLANES_PER_CYC planes per cycle
package keccak_pkg;
  localparam int ROW_SIZE = 5;
  localparam int COL_SIZE = 5;
  localparam int LANE_SIZE = 64;
endpackage

module chi_inv_engine
  import keccak_pkg::*;
#(
  parameter int PLANES_PER_CYC = 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
  output logic                                           valid_o,
  input  logic                                           ready_i,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_o,
  output logic                                           busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] src, res, inv;
  // closed-form 5-bit chi inverse: a[x] = b[x] ^ ~b[x+1] & (b[x+2] ^ ~b[x+3] & b[x+4])
  always_comb begin
    inv = '0;
    for (int x = 0; x < ROW_SIZE; x++)
      for (int y = 0; y < COL_SIZE; y++)
        inv[x][y] = src[x][y] ^ (~src[(x+1)%5][y] &
                    (src[(x+2)%5][y] ^ (~src[(x+3)%5][y] & src[(x+4)%5][y])));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      src   <= '0;
      res   <= '0;
    end else if (state == IDLE) begin
      if (valid_i) begin
        src   <= state_array_i;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      for (int p = 0; p < PLANES_PER_CYC; p++)
        for (int x = 0; x < ROW_SIZE; x++)
          if (int'(cnt) + p < COL_SIZE) res[x][int'(cnt)+p] <= inv[x][int'(cnt)+p];
      cnt <= cnt + 3'(PLANES_PER_CYC);
      if (int'(cnt) + PLANES_PER_CYC >= COL_SIZE) state <= DONE;
    end else if (ready_i) begin
      state <= IDLE;
    end
  end
  assign ready_o       = state == IDLE;
  assign valid_o       = state == DONE;
  assign busy_o        = state == RUN;
  assign state_array_o = res;
endmodule

// File: tb/tb_chi_inv_engine.sv
// tb_chi_inv_engine: random and directed checks of both PPC variants against a search-based chi inverse
module tb_chi_inv_engine;
  import keccak_pkg::*;
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] st_t;
  logic clk = 0, rst_n = 0, valid = 0, ready = 0;
  st_t din = '0;
  logic ready1, valid1, busy1, ready5, valid5, busy5;
  st_t dout1, dout5;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  chi_inv_engine #(.PLANES_PER_CYC(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready1), .state_array_i(din),
    .valid_o(valid1), .ready_i(ready), .state_array_o(dout1), .busy_o(busy1));
  chi_inv_engine #(.PLANES_PER_CYC(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready5), .state_array_i(din),
    .valid_o(valid5), .ready_i(ready), .state_array_o(dout5), .busy_o(busy5));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_state(input string tag, input st_t got, input st_t exp);
    int k = 0;
    for (int i = 24; i >= 0; i--) if (got[i/5][i%5] !== exp[i/5][i%5]) k = i;
    check($sformatf("%s[%0d][%0d]", tag, k/5, k%5), got[k/5][k%5], exp[k/5][k%5]);
  endtask
  function automatic logic [4:0] chi5(input logic [4:0] a);
    logic [4:0] r;
    for (int x = 0; x < 5; x++) r[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
    return r;
  endfunction
  function automatic st_t ref_chi(input st_t a);
    st_t o;
    logic [4:0] row;
    for (int y = 0; y < 5; y++)
      for (int z = 0; z < 64; z++) begin
        for (int x = 0; x < 5; x++) row[x] = a[x][y][z];
        row = chi5(row);
        for (int x = 0; x < 5; x++) o[x][y][z] = row[x];
      end
    return o;
  endfunction
  function automatic st_t ref_inv(input st_t b);
    st_t o;
    logic [4:0] row, pre;
    for (int y = 0; y < 5; y++)
      for (int z = 0; z < 64; z++) begin
        for (int x = 0; x < 5; x++) row[x] = b[x][y][z];
        pre = '0;
        for (int c = 0; c < 32; c++) if (chi5(5'(c)) == row) pre = 5'(c);
        for (int x = 0; x < 5; x++) o[x][y][z] = pre[x];
      end
    return o;
  endfunction
  function automatic st_t rand_st();
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) s[x][y] = {$urandom, $urandom};
    return s;
  endfunction
  task automatic job(input string name, input st_t a, input st_t exp, input int stall);
    int l1 = 0, l5 = 0;
    din = a;
    valid = 1;
    tick;
    valid = 0;
    din = rand_st();
    check({name, " rdy/busy"}, 64'({ready1, busy1, ready5}), 64'(3'b010));
    for (int n = 1; n <= 20 && (l1 == 0 || l5 == 0); n++) begin
      valid = 1'($urandom_range(0, 1));
      din = rand_st();
      tick;
      if (l1 == 0 && valid1) l1 = n;
      if (l5 == 0 && valid5) l5 = n;
    end
    valid = 0;
    check({name, " lat1"}, 64'(l1), 64'd5);
    check({name, " lat5"}, 64'(l5), 64'd1);
    chk_state({name, " out1"}, dout1, exp);
    chk_state({name, " out5"}, dout5, exp);
    for (int s = 0; s < stall; s++) begin
      tick;
      check({name, " stall valid"}, 64'({valid1, valid5}), 64'(2'b11));
      chk_state({name, " stall out1"}, dout1, exp);
    end
    ready = 1;
    tick;
    ready = 0;
    check({name, " idle"}, 64'({ready1, ready5, valid1, valid5}), 64'(4'b1100));
  endtask
  st_t a, e;
  initial begin
    tick;
    tick;
    check("rst ctl1", 64'({ready1, valid1, busy1}), 64'(3'b100));
    check("rst ctl5", 64'({ready5, valid5, busy5}), 64'(3'b100));
    chk_state("rst out1", dout1, '0);
    chk_state("rst out5", dout5, '0);
    rst_n = 1;
    job("zero", '0, '0, 0);
    a = '0; a[1][0] = 64'h1; a[4][0] = 64'h1;
    e = '0; e[1][0] = 64'h1;
    job("x1x4", a, e, 0);
    a = '0; a[0][0] = 64'h1; a[3][0] = 64'h1;
    e = '0; e[0][0] = 64'h1;
    job("x0x3", a, e, 0);
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) a[x][y] = 64'h1;
    job("ones", a, a, 0);
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) e[x][y] = 64'(5*x + y);
    job("seq", ref_chi(e), e, 0);
    for (int i = 0; i < 4; i++) begin
      a = rand_st();
      job($sformatf("rnd%0d", i), a, ref_inv(a), 0);
    end
    e = rand_st();
    job("roundtrip", ref_chi(e), e, 0);
    a = rand_st();
    job("stall", a, ref_inv(a), 10);
    din = rand_st();
    valid = 1;
    tick;
    valid = 0;
    tick;
    tick;
    check("abort busy", 64'({busy1, valid5}), 64'(2'b11));
    rst_n = 0;
    valid = 1;
    ready = 1;
    tick;
    valid = 0;
    ready = 0;
    check("abort ctl1", 64'({ready1, valid1, busy1}), 64'(3'b100));
    check("abort ctl5", 64'({ready5, valid5, busy5}), 64'(3'b100));
    chk_state("abort out1", dout1, '0);
    chk_state("abort out5", dout5, '0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("post abort", 64'({ready1, valid1, ready5, valid5}), 64'(4'b1010));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chi_inv_engine.md
CHI_INV_ENGINE -- requirements
Module: chi_inv_engine

Interface
REQ-001 The module SHALL have parameter PLANES_PER_CYC, default 1, giving the planes inverted per RUN cycle; legal values are 1 and 5 only.
REQ-002 The module SHALL take all geometry from keccak_pkg (ROW_SIZE=5, COL_SIZE=5, LANE_SIZE=64); state arrays are packed [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0], indexed [x][y].
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port valid_i, input, 1 bit: state_array_i holds a valid state.
REQ-006 The module SHALL have port ready_o, output, 1 bit: the engine can accept a state.
REQ-007 The module SHALL have port state_array_i, input, 1600 bits: the state to invert, which is a chi output.
REQ-008 The module SHALL have port valid_o, output, 1 bit: state_array_o holds the result.
REQ-009 The module SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-010 The module SHALL have port state_array_o, output, 1600 bits: the inverted state, which is the chi preimage.
REQ-011 The module SHALL have port busy_o, output, 1 bit: high while the FSM is in RUN.

Function
REQ-012 The forward chi map is A'[x][y][z] = A[x][y][z] ^ (~A[(x+1)%5][y][z] & A[(x+2)%5][y][z]); for every (y,z), output row bits x=0..4 SHALL be the unique 5-bit preimage of input row bits x=0..4 under this map.
REQ-013 The module SHALL use the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE, ready_o SHALL be 1 and valid_o SHALL be 0; valid_i&&ready_o SHALL capture state_array_i into an internal source register, clear the plane counter to 0 and go to RUN.
REQ-015 In RUN, each cycle SHALL write PLANES_PER_CYC planes (y = cnt .. cnt+PLANES_PER_CYC-1) of the result register from the source register, then advance cnt by PLANES_PER_CYC.
REQ-016 The plane counter SHALL be 3 bits wide; when the last plane (y=4) is written, the FSM SHALL go to DONE and SHALL NOT wrap cnt to process further planes.
REQ-017 Latency SHALL be exactly 5/PLANES_PER_CYC RUN cycles: if acceptance is at edge k, valid_o is first high after edge k+5 (PPC=1) or edge k+1 (PPC=5).
REQ-018 In DONE, valid_o SHALL be 1 and state_array_o SHALL be held stable until valid_o&&ready_i, after which the FSM SHALL go to IDLE.
REQ-019 ready_o SHALL be 0 in RUN and DONE; there is no same-cycle turnaround, so a new input is accepted at the earliest one cycle after output acceptance.
REQ-020 valid_i SHALL be ignored outside IDLE; state_array_i changes outside IDLE SHALL NOT affect the result.
REQ-021 ready_i SHALL be ignored outside DONE.
REQ-022 state_array_o SHALL be driven directly from the result register; planes not yet written in RUN are don't-care to observers because valid_o=0.

Reset
REQ-023 With rst_ni=0 at a rising edge, the FSM SHALL go to IDLE, cnt SHALL be 0, and the source and result registers SHALL be 0.
REQ-024 During and after reset, outputs SHALL be ready_o=1, valid_o=0, busy_o=0 and state_array_o=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no partial output and no valid_o pulse.
REQ-026 Reset SHALL take priority over a simultaneous valid_i or ready_i.

Verification
REQ-027 The bench SHALL drive all-zero state_array_i with PPC=1 and SHALL check valid_o after exactly 5 RUN cycles with state_array_o all zero.
REQ-028 The bench SHALL drive input lanes [1][0]=[4][0]=64'h1, others 0, and SHALL check output [1][0]=64'h1 and all other lanes 0.
REQ-029 The bench SHALL drive input lanes [0][0]=[3][0]=64'h1, others 0, and SHALL check output [0][0]=64'h1 and all other lanes 0.
REQ-030 The bench SHALL drive every lane = 64'h1 and SHALL check every output lane = 64'h1, since the state is a chi fixed point.
REQ-031 The bench SHALL apply the sequential pattern (lane [x][y] = 5x+y) through a reference chi, invert it, and SHALL check that the original is recovered for both PPC=1 and PPC=5.
REQ-032 The bench SHALL hold ready_i=0 for 10 cycles in DONE, then pulse rst_ni low in mid-RUN of a second job, and SHALL check that the output stays stable while stalled and that reset gives valid_o=0, ready_o=1 and state_array_o=0.
